// File: rtl/modq_addsub_pipe_if.sv
// modq_addsub_pipe_if: operand/result handshake bundle for modq_addsub_pipe.
interface modq_addsub_pipe_if #(parameter int LANE_W = 12);
    logic [1:0]          mode;
    logic                sel_a_dly;
    logic                sel_b_dly;
    logic [2*LANE_W-1:0] in_a;
    logic [2*LANE_W-1:0] in_b;
    logic                in_valid;
    logic                in_ready;
    logic [2*LANE_W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                range_err;
    modport master (
        output mode, sel_a_dly, sel_b_dly, in_a, in_b, in_valid, out_ready,
        input  in_ready, out_data, out_valid, range_err
    );
    modport slave (
        input  mode, sel_a_dly, sel_b_dly, in_a, in_b, in_valid, out_ready,
        output in_ready, out_data, out_valid, range_err
    );
endinterface

// File: rtl/modq_addsub_pipe.sv
// modq_addsub_pipe: 2-stage Kyber (2 lanes mod KQ) / Dilithium (mod DQ) modular add/sub.
// Define MODQ_RANGE_CHECK_EN to build the sticky operand-range checker driving range_err.
module modq_addsub_pipe #(
    parameter int LANE_W = 12,
    parameter int KQ     = 3329,
    parameter int DQ     = 8380417,
    parameter int A_DLY  = 6,
    parameter int B_DLY  = 7
) (
    input logic              clk,
    input logic              rst,
    modq_addsub_pipe_if.slave bus
);
    localparam int W = 2 * LANE_W;
    localparam logic [LANE_W-1:0] KQ_L = KQ[LANE_W-1:0];
    localparam logic [W-1:0]      DQ_L = DQ[W-1:0];

    logic [W-1:0]  r_a_dly [A_DLY];
    logic [W-1:0]  r_b_dly [B_DLY];
    logic [W-1:0]  w_a, w_b;
    logic          w_dil_in, w_accept, w_s2_adv;
    logic [LANE_W:0] w_k_lo, w_k_hi;
    logic [W:0]    w_d;
    logic [W+1:0]  w_s1_sum, r_s1_sum;
    logic [1:0]    r_s1_mode;
    logic          r_s1_valid, r_s2_valid;
    logic          w_dil;
    logic [LANE_W:0] w_lo_s, w_hi_s;
    logic [W:0]    w_d_s;
    logic [LANE_W-1:0] w_lo_r, w_hi_r;
    logic [W-1:0]  w_d_r, w_res, r_out_data;

    // Delay lines shift every cycle, independent of the handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < A_DLY; i++) r_a_dly[i] <= '0;
            for (int i = 0; i < B_DLY; i++) r_b_dly[i] <= '0;
        end else begin
            r_a_dly[0] <= bus.in_a;
            r_b_dly[0] <= bus.in_b;
            for (int i = 1; i < A_DLY; i++) r_a_dly[i] <= r_a_dly[i-1];
            for (int i = 1; i < B_DLY; i++) r_b_dly[i] <= r_b_dly[i-1];
        end
    end

    assign w_a          = bus.sel_a_dly ? r_a_dly[A_DLY-1] : bus.in_a;
    assign w_b          = bus.sel_b_dly ? r_b_dly[B_DLY-1] : bus.in_b;
    assign w_dil_in     = bus.mode == 2'b01 || bus.mode == 2'b10;
    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign bus.in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        w_k_lo   = (bus.mode == 2'b00) ? {1'b0, w_a[LANE_W-1:0]} - {1'b0, w_b[LANE_W-1:0]}
                                       : {1'b0, w_a[LANE_W-1:0]} + {1'b0, w_b[LANE_W-1:0]};
        w_k_hi   = (bus.mode == 2'b11) ? {1'b0, w_a[W-1:LANE_W]} - {1'b0, w_b[W-1:LANE_W]}
                                       : {1'b0, w_a[W-1:LANE_W]} + {1'b0, w_b[W-1:LANE_W]};
        w_d      = (bus.mode == 2'b10) ? {1'b0, w_a} - {1'b0, w_b} : {1'b0, w_a} + {1'b0, w_b};
        w_s1_sum = w_dil_in ? {1'b0, w_d} : {w_k_hi, w_k_lo};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_mode  <= '0;
        end else begin
            if (bus.in_ready) r_s1_valid <= bus.in_valid;
            if (w_accept) begin
                r_s1_sum  <= w_s1_sum;
                r_s1_mode <= bus.mode;
            end
        end
    end

    // Top bit of each raw value is carry (add) or borrow (sub).
    always_comb begin
        w_dil  = r_s1_mode[0] ^ r_s1_mode[1];
        w_lo_s = r_s1_sum[LANE_W:0];
        w_hi_s = r_s1_sum[W+1:LANE_W+1];
        w_d_s  = r_s1_sum[W:0];
        w_lo_r = (r_s1_mode == 2'b00)
               ? (w_lo_s[LANE_W] ? w_lo_s[LANE_W-1:0] + KQ_L : w_lo_s[LANE_W-1:0])
               : (w_lo_s >= {1'b0, KQ_L} ? w_lo_s[LANE_W-1:0] - KQ_L : w_lo_s[LANE_W-1:0]);
        w_hi_r = (r_s1_mode == 2'b11)
               ? (w_hi_s[LANE_W] ? w_hi_s[LANE_W-1:0] + KQ_L : w_hi_s[LANE_W-1:0])
               : (w_hi_s >= {1'b0, KQ_L} ? w_hi_s[LANE_W-1:0] - KQ_L : w_hi_s[LANE_W-1:0]);
        w_d_r  = (r_s1_mode == 2'b10)
               ? (w_d_s[W] ? w_d_s[W-1:0] + DQ_L : w_d_s[W-1:0])
               : (w_d_s >= {1'b0, DQ_L} ? w_d_s[W-1:0] - DQ_L : w_d_s[W-1:0]);
        w_res  = w_dil ? w_d_r : {w_hi_r, w_lo_r};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) r_out_data <= w_res;
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_out_data;

`ifdef MODQ_RANGE_CHECK_EN
    logic r_range_err, w_hit;
    always_comb begin
        w_hit = w_dil_in ? (w_a >= DQ_L || w_b >= DQ_L)
                         : (w_a[LANE_W-1:0] >= KQ_L || w_a[W-1:LANE_W] >= KQ_L ||
                            w_b[LANE_W-1:0] >= KQ_L || w_b[W-1:LANE_W] >= KQ_L);
    end
    always_ff @(posedge clk) begin
        if (!rst) r_range_err <= 1'b0;
        else if (w_accept && w_hit) r_range_err <= 1'b1;
    end
    assign bus.range_err = r_range_err;
`else
    assign bus.range_err = 1'b0;
`endif
endmodule

// File: tb/tb_modq_addsub_pipe.sv
// tb_modq_addsub_pipe: directed checks of modq_addsub_pipe arithmetic, latency, flow control and reset.
module tb_modq_addsub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;

    modq_addsub_pipe_if #(.LANE_W(12)) bus ();
    modq_addsub_pipe dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] m, input logic [23:0] a, input logic [23:0] b, input logic v);
        bus.mode = m;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks += 4;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0d exp=0", bus.out_valid); end
        if (bus.out_data !== 24'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
        if (bus.range_err !== 1'b0) begin failures++; $display("FAIL reset_range_err got=%0d exp=0", bus.range_err); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0d exp=1", bus.in_ready); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_kyber_00();
        drive(2'b00, {12'd3000, 12'd100}, {12'd1000, 12'd200}, 1'b1);
        step();
        drive(2'b00, 24'd0, 24'd0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL k00_early_valid got=%0d exp=0", bus.out_valid); end
        step();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL k00_valid got=%0d exp=1", bus.out_valid); end
        if (bus.out_data !== {12'd671, 12'd3229}) begin failures++; $display("FAIL k00_data got=%h exp=%h", bus.out_data, {12'd671, 12'd3229}); end
        step();
    endtask

    task automatic test_dilithium_back_to_back();
        drive(2'b01, 24'd8380416, 24'd1, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL d_b2b_ready1 got=%0d exp=1", bus.in_ready); end
        step();
        drive(2'b01, 24'd5000000, 24'd4000000, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL d_b2b_ready2 got=%0d exp=1", bus.in_ready); end
        step();
        drive(2'b01, 24'd0, 24'd0, 1'b0);
        checks += 2;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL d_b2b_valid1 got=%0d exp=1", bus.out_valid); end
        if (bus.out_data !== 24'd0) begin failures++; $display("FAIL d_b2b_data1 got=%0d exp=0", bus.out_data); end
        step();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL d_b2b_valid2 got=%0d exp=1", bus.out_valid); end
        if (bus.out_data !== 24'd619583) begin failures++; $display("FAIL d_b2b_data2 got=%0d exp=619583", bus.out_data); end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL d_b2b_drain got=%0d exp=0", bus.out_valid); end
    endtask

    task automatic test_sub_modes();
        drive(2'b10, 24'd0, 24'd1, 1'b1);
        step();
        drive(2'b11, {12'd5, 12'd5}, {12'd7, 12'd7}, 1'b1);
        step();
        drive(2'b00, 24'd0, 24'd0, 1'b0);
        checks++;
        if (bus.out_data !== 24'd8380416) begin failures++; $display("FAIL d_sub_data got=%0d exp=8380416", bus.out_data); end
        step();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL k11_valid got=%0d exp=1", bus.out_valid); end
        if (bus.out_data !== {12'd3327, 12'd12}) begin failures++; $display("FAIL k11_data got=%h exp=%h", bus.out_data, {12'd3327, 12'd12}); end
        step();
    endtask

    task automatic test_stall();
        logic [23:0] exp_q [4];
        int sent;
        int got;
        exp_q = '{24'd11, 24'd21, 24'd31, 24'd41};
        sent = 0;
        got = 0;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(2'b01, 24'(10 * (sent + 1)), 24'd1, sent < 4);
            #1;
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        checks += 4;
        if (sent !== 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", sent); end
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready got=%0d exp=0", bus.in_ready); end
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid got=%0d exp=1", bus.out_valid); end
        if (bus.out_data !== 24'd11) begin failures++; $display("FAIL stall_held_data got=%0d exp=11", bus.out_data); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            drive(2'b01, 24'(10 * (sent + 1)), 24'd1, sent < 4);
            #1;
            if (bus.out_valid) begin
                checks++;
                if (bus.out_data !== exp_q[got]) begin failures++; $display("FAIL stall_order[%0d] got=%0d exp=%0d", got, bus.out_data, exp_q[got]); end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        drive(2'b01, 24'd0, 24'd0, 1'b0);
        checks += 3;
        if (got !== 4) begin failures++; $display("FAIL stall_delivered got=%0d exp=4", got); end
        if (sent !== 4) begin failures++; $display("FAIL stall_sent got=%0d exp=4", sent); end
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_no_dup got=%0d exp=0", bus.out_valid); end
    endtask

    task automatic test_delay_line();
        bus.sel_b_dly = 1'b1;
        bus.out_ready = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            drive(2'b01, 24'd0, 24'(n), 1'b1);
            #1;
            if (n >= 10) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 24'(n - 9))
                    begin failures++; $display("FAIL b_delay[%0d] valid=%0d got=%0d exp=%0d", n, bus.out_valid, bus.out_data, n - 9); end
            end
            step();
        end
        drive(2'b01, 24'd0, 24'd0, 1'b0);
        bus.sel_b_dly = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_midflight();
        int stale;
        stale = 0;
        drive(2'b01, 24'd1, 24'd2, 1'b1);
        step();
        drive(2'b01, 24'd3, 24'd4, 1'b1);
        step();
        drive(2'b01, 24'd0, 24'd0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%0d exp=1", bus.out_valid); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0d exp=0", bus.out_valid); end
        if (bus.out_data !== 24'd0) begin failures++; $display("FAIL mid_rst_data got=%0d exp=0", bus.out_data); end
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.out_valid) stale++;
        end
        checks++;
        if (stale !== 0) begin failures++; $display("FAIL mid_stale_beats got=%0d exp=0", stale); end
    endtask

    task automatic test_range_check();
        checks++;
        if (bus.range_err !== 1'b0) begin failures++; $display("FAIL range_clean got=%0d exp=0", bus.range_err); end
        drive(2'b00, {12'd0, 12'd3329}, 24'd0, 1'b1);
        step();
        drive(2'b00, 24'd0, 24'd0, 1'b0);
        step();
        step();
`ifdef MODQ_RANGE_CHECK_EN
        checks++;
        if (bus.range_err !== 1'b1) begin failures++; $display("FAIL range_set got=%0d exp=1", bus.range_err); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (bus.range_err !== 1'b0) begin failures++; $display("FAIL range_cleared got=%0d exp=0", bus.range_err); end
`else
        checks++;
        if (bus.range_err !== 1'b0) begin failures++; $display("FAIL range_tied got=%0d exp=0", bus.range_err); end
`endif
    endtask

    initial begin
        bus.mode = 2'b00;
        bus.sel_a_dly = 1'b0;
        bus.sel_b_dly = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_kyber_00();
        test_dilithium_back_to_back();
        test_sub_modes();
        test_stall();
        test_delay_line();
        test_reset_midflight();
        test_range_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
